// File: rtl/rggen_register_access_arbiter.sv
// Round-robin arbiter sharing one rggen register bus between HOSTS host ports; 2-cycle minimum request->host_ready latency.
// Hosts hold requests until host_ready; optional hung-access timeout enabled by `define RGGEN_ACCESS_TIMEOUT_EN.
module rggen_register_access_arbiter #(
    parameter int HOSTS          = 2,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [HOSTS-1:0]                host_request,
    input  logic [HOSTS-1:0]                host_direction,
    input  logic [HOSTS*ADDRESS_WIDTH-1:0]  host_address,
    input  logic [HOSTS*DATA_WIDTH-1:0]     host_write_data,
    input  logic [HOSTS*DATA_WIDTH-1:0]     host_write_mask,
    output logic [HOSTS-1:0]                host_ready,
    output logic [1:0]                      host_status,
    output logic [DATA_WIDTH-1:0]           host_read_data,
    output logic                            bus_request,
    output logic                            bus_direction,
    output logic [ADDRESS_WIDTH-1:0]        bus_address,
    output logic [DATA_WIDTH-1:0]           bus_write_data,
    output logic [DATA_WIDTH-1:0]           bus_write_mask,
    input  logic                            bus_select,
    input  logic                            bus_ready,
    input  logic [1:0]                      bus_status,
    input  logic [DATA_WIDTH-1:0]           bus_read_data
);

    localparam int PTR_W = (HOSTS > 1) ? $clog2(HOSTS) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    localparam logic [1:0] RGGEN_SLAVE_ERROR  = 2'b10;
    localparam logic [1:0] RGGEN_DECODE_ERROR = 2'b11;

    if ((HOSTS < 2) || (HOSTS > 8)) begin : g_hosts_range_check
        $error("HOSTS must be within 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0]               state_q,          state_d;
    logic [PTR_W-1:0]         rr_ptr_q,         rr_ptr_d;
    logic [PTR_W-1:0]         grant_q,          grant_d;
    logic [HOSTS-1:0]         host_ready_q,     host_ready_d;
    logic [1:0]               host_status_q,    host_status_d;
    logic [DATA_WIDTH-1:0]    host_read_data_q, host_read_data_d;
    logic                     bus_request_q,    bus_request_d;
    logic                     bus_direction_q,  bus_direction_d;
    logic [ADDRESS_WIDTH-1:0] bus_address_q,    bus_address_d;
    logic [DATA_WIDTH-1:0]    bus_write_data_q, bus_write_data_d;
    logic [DATA_WIDTH-1:0]    bus_write_mask_q, bus_write_mask_d;

    logic                     grant_vld;
    logic [PTR_W-1:0]         grant_idx;
    logic                     timeout_hit;
    logic                     access_done;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned      offset);
        int unsigned sum;
        sum = 32'(base) + offset;
        if (sum >= 32'(HOSTS)) begin
            sum = sum - 32'(HOSTS);
        end
        return PTR_W'(sum);
    endfunction

    // Scan from the farthest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < HOSTS; i++) begin
            if (host_request[wrap_add(rr_ptr_q, 32'(HOSTS - 1 - i))]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(rr_ptr_q, 32'(HOSTS - 1 - i));
            end
        end
    end

`ifdef RGGEN_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] timeout_count_q, timeout_count_d;

    assign timeout_hit = (timeout_count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        timeout_count_d = timeout_count_q;
        if (state_q != ACCESS) begin
            timeout_count_d = '0;
        end else if (!access_done) begin
            timeout_count_d = timeout_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_count_q <= '0;
        end else begin
            timeout_count_q <= timeout_count_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign access_done = (state_q == ACCESS) && (!bus_select || bus_ready || timeout_hit);

    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        grant_d          = grant_q;
        host_ready_d     = '0;
        host_status_d    = host_status_q;
        host_read_data_d = host_read_data_q;
        bus_request_d    = bus_request_q;
        bus_direction_d  = bus_direction_q;
        bus_address_d    = bus_address_q;
        bus_write_data_d = bus_write_data_q;
        bus_write_mask_d = bus_write_mask_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d          = ACCESS;
                    grant_d          = grant_idx;
                    rr_ptr_d         = wrap_add(grant_idx, 32'd1);
                    bus_request_d    = 1'b1;
                    bus_direction_d  = host_direction[grant_idx];
                    bus_address_d    = host_address[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    bus_write_data_d = host_write_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    bus_write_mask_d = host_write_mask[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            ACCESS: begin
                // Decode error outranks ready, and ready outranks the timeout.
                if (!bus_select) begin
                    host_status_d    = RGGEN_DECODE_ERROR;
                    host_read_data_d = '0;
                end else if (bus_ready) begin
                    host_status_d    = bus_status;
                    host_read_data_d = bus_direction_q ? '0 : bus_read_data;
                end else if (timeout_hit) begin
                    host_status_d    = RGGEN_SLAVE_ERROR;
                    host_read_data_d = '0;
                end
                if (access_done) begin
                    state_d               = RESPOND;
                    bus_request_d         = 1'b0;
                    host_ready_d[grant_q] = 1'b1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d       = IDLE;
                bus_request_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            rr_ptr_q         <= '0;
            grant_q          <= '0;
            host_ready_q     <= '0;
            host_status_q    <= '0;
            host_read_data_q <= '0;
            bus_request_q    <= 1'b0;
            bus_direction_q  <= 1'b0;
            bus_address_q    <= '0;
            bus_write_data_q <= '0;
            bus_write_mask_q <= '0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            grant_q          <= grant_d;
            host_ready_q     <= host_ready_d;
            host_status_q    <= host_status_d;
            host_read_data_q <= host_read_data_d;
            bus_request_q    <= bus_request_d;
            bus_direction_q  <= bus_direction_d;
            bus_address_q    <= bus_address_d;
            bus_write_data_q <= bus_write_data_d;
            bus_write_mask_q <= bus_write_mask_d;
        end
    end

    assign host_ready     = host_ready_q;
    assign host_status    = host_status_q;
    assign host_read_data = host_read_data_q;
    assign bus_request    = bus_request_q;
    assign bus_direction  = bus_direction_q;
    assign bus_address    = bus_address_q;
    assign bus_write_data = bus_write_data_q;
    assign bus_write_mask = bus_write_mask_q;

endmodule
